// File: rtl/axi_mm_mem_arbiter.sv
// axi_mm_mem_arbiter: two-requester round-robin arbiter with per-grant burst limit onto one
// byte-strobed block-RAM port. Define AXI_MM_MEM_ARB_FIXED_PRIO_EN for fixed priority to requester 0.
module axi_mm_mem_arbiter #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int OPT_MEM_ADDR_BITS  = 10,
    parameter int MAX_BURST          = 4
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                req0_valid,
    output logic                                req0_ready,
    input  logic                                req0_we,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]     req0_wstrb,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]       req0_wdata,
    input  logic [OPT_MEM_ADDR_BITS:0]          req0_addr,
    output logic                                rsp0_valid,
    output logic [C_S_AXI_DATA_WIDTH-1:0]       rsp0_rdata,
    input  logic                                req1_valid,
    output logic                                req1_ready,
    input  logic                                req1_we,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]     req1_wstrb,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]       req1_wdata,
    input  logic [OPT_MEM_ADDR_BITS:0]          req1_addr,
    output logic                                rsp1_valid,
    output logic [C_S_AXI_DATA_WIDTH-1:0]       rsp1_rdata,
    output logic                                mem_wen,
    output logic                                mem_ren,
    output logic [C_S_AXI_DATA_WIDTH/8-1:0]     mem_wstrb,
    output logic [C_S_AXI_DATA_WIDTH-1:0]       mem_wdata,
    output logic [OPT_MEM_ADDR_BITS:0]          mem_addr,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]       mem_rdata
);
    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

    state_t     state_q, state_d;
    logic       ptr_q, ptr_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] rsp_q;
    logic       sel, v_sel, v_oth, beat, we_sel, at_limit, may_yield;
    state_t     other;

`ifdef AXI_MM_MEM_ARB_FIXED_PRIO_EN
    localparam bit FIXED_PRIO = 1'b1;
`else
    localparam bit FIXED_PRIO = 1'b0;
`endif

    // Arbitration, burst counting and combinational memory port drive from the granted requester
    always_comb begin
        sel        = (state_q == GRANT1);
        req0_ready = (state_q == GRANT0);
        req1_ready = (state_q == GRANT1);
        v_sel      = sel ? req1_valid : req0_valid;
        v_oth      = sel ? req0_valid : req1_valid;
        we_sel     = sel ? req1_we : req0_we;
        other      = sel ? GRANT0 : GRANT1;
        beat       = (state_q != IDLE) && v_sel;
        at_limit   = (cnt_q >= 8'(MAX_BURST - 1));
        // Under fixed priority only requester 1 is bounded by the burst limit
        may_yield  = !FIXED_PRIO || sel;
        mem_wen    = beat && we_sel;
        mem_ren    = beat && !we_sel;
        mem_addr   = sel ? req1_addr : req0_addr;
        mem_wdata  = sel ? req1_wdata : req0_wdata;
        mem_wstrb  = sel ? req1_wstrb : req0_wstrb;
        state_d    = state_q;
        if (state_q == IDLE) begin
            // Round-robin tie goes to the requester that was not granted last
            if (req0_valid && (!req1_valid || ptr_q || FIXED_PRIO))
                state_d = GRANT0;
            else if (req1_valid)
                state_d = GRANT1;
        end else if (!v_sel) begin
            state_d = v_oth ? other : IDLE;
        end else if (v_oth && at_limit && may_yield) begin
            state_d = other;
        end
        cnt_d = (state_d != state_q) ? 8'd0 :
                (beat && cnt_q != 8'(MAX_BURST)) ? cnt_q + 8'd1 : cnt_q;
        ptr_d = (state_d == GRANT0) ? 1'b0 : (state_d == GRANT1) ? 1'b1 : ptr_q;
    end

    // State, pointer, beat counter and read-response tag registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= 1'b1;
            cnt_q   <= 8'd0;
            rsp_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            rsp_q   <= {mem_ren && sel, mem_ren && !sel};
        end
    end

    assign rsp0_valid = rsp_q[0];
    assign rsp1_valid = rsp_q[1];
    assign rsp0_rdata = mem_rdata;
    assign rsp1_rdata = mem_rdata;
endmodule

// File: doc/axi_mm_mem_arbiter.md
# axi_mm_mem_arbiter

Two-requester arbiter that shares a single byte-strobed block-RAM port (wen/wstrb/wdata/ren/addr, 1-cycle registered read) between an AXI-MM slave front end (requester 0) and a local engine (requester 1). It grants one requester at a time with round-robin fairness and a per-grant burst limit, drives the memory port from the granted requester, and routes read data back with a per-requester response pulse.

## Interface
- C_S_AXI_DATA_WIDTH, 32, data width; wstrb width = C_S_AXI_DATA_WIDTH/8
- OPT_MEM_ADDR_BITS, 10, address MSB index; address width = OPT_MEM_ADDR_BITS+1
- MAX_BURST, 4, max consecutive beats per grant while the other requester waits (1..255)
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset: synchronous, active-low
- reqN_valid  in  1  requester N (N=0,1) beat request
- reqN_ready  out  1  beat accepted this cycle when valid&ready
- reqN_we  in  1  1=write, 0=read
- reqN_wstrb  in  DW/8  byte enables for write
- reqN_wdata  in  DW  write data
- reqN_addr  in  AW  word address
- rspN_valid  out  1  one-cycle pulse: read data for N on rspN_rdata
- rspN_rdata  out  DW  read data (mem_rdata passthrough)
- mem_wen, mem_ren  out  1  memory write/read enable
- mem_wstrb  out  DW/8; mem_wdata  out  DW; mem_addr  out  AW
- mem_rdata  in  DW  memory read data, valid the cycle after mem_ren

## Operation
- States: IDLE, GRANT0, GRANT1 (registered). Round-robin pointer ptr (1 bit) = last granted requester; beat counter cnt (8 bit).
- IDLE: neither valid -> stay. One valid -> GRANT of that one. Both valid -> GRANT of requester != ptr.
- GRANTn: reqn_ready=1, other ready=0. Accepted beat drives mem_* combinationally: mem_wen=we, mem_ren=!we, addr/wdata/wstrb from reqn; mem_wen=mem_ren=0 when no accepted beat.
- cnt increments per accepted beat; cleared on every state change.
- Leave GRANTn when reqn_valid=0 (-> GRANT other if other valid, else IDLE), or when cnt reaches MAX_BURST with accepted beat and other valid (-> GRANT other). Other idle at limit: stay, cnt holds at MAX_BURST.
- ptr updates to n on entry to GRANTn.
- Reads: tag register records issuing requester; rspN_valid registered = (mem_ren issued by N last cycle). Writes produce no response.
- Only one memory access per cycle; no reordering; responses in issue order.

## Timing
- Reset: state=IDLE, ptr=1 (requester 0 wins first tie), cnt=0, reqN_ready=0, rspN_valid=0, mem_wen=mem_ren=0.
- Arbitration latency: valid seen in IDLE at cycle k -> ready at k+1. Back-to-back handover GRANTn->GRANTm costs zero idle cycles.
- Read latency: accept at cycle k -> rspN_valid and rspN_rdata at k+1.
- Throughput: 1 beat/cycle within a grant.
- Reset mid-burst: grant dropped immediately, in-flight read response suppressed (rsp_valid=0 after reset edge).
- Requester dropping valid mid-grant: ready stays high that cycle but no beat issues; re-arbitrate next cycle.

## Configuration
- AXI_MM_MEM_ARB_FIXED_PRIO_EN defined: requester 0 wins every arbitration point (IDLE tie and burst-limit handover); requester 1 granted only when req0_valid=0; MAX_BURST applies only to requester 1 (requester 1 yields to 0 at limit). Starvation of requester 1 is permitted.
- Undefined: round-robin as above.

## Test plan
- Reset, then req0 read addr 5 (mem holds 0xA5A5_0005) -> ready cycle 1, mem_ren cycle 1, rsp0_valid=1 rsp0_rdata=0xA5A5_0005 cycle 2, rsp1_valid=0.
- Both valid from IDLE after reset -> GRANT0 first; continuous writes -> 4 beats req0, 4 beats req1, alternating, no gap cycles.
- req1 write wstrb=4'b0010 wdata=0x0000_AB00 addr 3 -> mem_wen=1, mem_wstrb=0010, mem_addr=3, no rsp pulse.
- req0 only, 10 continuous reads -> all 10 accepted back-to-back, cnt saturates, no handover.
- Reset asserted cycle after read accept -> rsp0_valid stays 0, state IDLE, all mem enables 0.
- With AXI_MM_MEM_ARB_FIXED_PRIO_EN, both continuous -> req0 granted every beat, req1_ready=0 throughout.
